// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave port among NUM_REQ requesters.
// A grant lasts up to BURST_LEN handshakes and always ends with one IDLE bubble cycle.
module vr_rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int DATA_W    = 3,
   parameter int BURST_LEN = 4
) (
   input  logic                      sys_clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e          state_q;
   logic [ID_W-1:0] grant_q;
   logic [ID_W-1:0] last_ptr_q;
   logic [7:0]      beat_cnt_q;

   logic [ID_W-1:0] winner_d;
   logic [ID_W-1:0] idx;
   logic            found;
   logic            any_req;
   logic            granted;
   logic            hs;
   logic            last_beat;

   // Search starts one past the last winner so the previous owner has lowest priority.
   always_comb begin
      winner_d = '0;
      idx      = '0;
      found    = 1'b0;
      any_req  = |req_valid;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(last_ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            winner_d = idx;
            found    = 1'b1;
         end
      end
   end

   assign granted   = (state_q == GRANT);
   assign out_valid = granted & req_valid[grant_q];
   assign out_data  = granted ? req_data[grant_q*DATA_W +: DATA_W] : '0;
   assign hs        = out_valid & out_ready;
   assign last_beat = (beat_cnt_q == 8'(BURST_LEN-1));
   assign grant_id  = grant_q;
   assign busy      = granted;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign req_ready[i] = granted && (grant_q == ID_W'(i)) && out_ready;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_ptr_q <= ID_W'(NUM_REQ-1);
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q    <= winner_d;
                  last_ptr_q <= winner_d;
                  beat_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               // Last-beat completion wins over a simultaneous valid drop.
               if (hs && last_beat) begin
                  state_q    <= IDLE;
                  beat_cnt_q <= '0;
               end else if (!req_valid[grant_q]) begin
                  state_q    <= IDLE;
                  beat_cnt_q <= '0;
               end else if (hs) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter: expected handshakes are queued by the stimulus
// and checked by an independent monitor on each slave-side handshake.
module tb_vr_rr_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int DATA_W  = 3;

   typedef logic [ID_W+DATA_W+NUM_REQ-1:0] item_t;

   logic                      sys_clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   int    vectors    = 0;
   int    miscompares = 0;
   item_t exp_q[$];

   vr_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .BURST_LEN(4)) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Requester payloads: r0=011 r1=110 r2=101 r3=111
   function automatic logic [2:0] dat(input int i);
      case (i)
         0:       return 3'b011;
         1:       return 3'b110;
         2:       return 3'b101;
         default: return 3'b111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int id);
      logic [ID_W-1:0] idv;
      idv = ID_W'(id);
      exp_q.push_back({idv, dat(id), 4'(4'd1 << idv)});
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      rst_n = 1'b1;
   endtask

   // Monitor: every slave-side handshake must match the head of the queue.
   always @(negedge sys_clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_hs: got id=%0d data=%0b, none expected (t=%0t)",
                     grant_id, out_data, $time);
         end else begin
            item_t e;
            e = exp_q.pop_front();
            chk("hs_id_data_ready", 32'({grant_id, out_data, req_ready}), 32'(e));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      req_data  = {dat(3), dat(2), dat(1), dat(0)};
      tick();
      tick();
      rst_n = 1'b1;

      // 1: asynchronous reset mid-cycle while requester 1 holds the grant
      req_valid = 4'b0010;
      tick();
      chk("t1_grant_id", 32'(grant_id), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_data", 32'(out_data), 32'(3'b110));
      chk("t1_ready_bp", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t1_rst_req_ready", 32'(req_ready), 32'd0);
      chk("t1_rst_busy", 32'(busy), 32'd0);
      chk("t1_rst_grant_id", 32'(grant_id), 32'd0);
      chk("t1_rst_out_data", 32'(out_data), 32'd0);
      req_valid = '0;
      tick();
      rst_n = 1'b1;

      // 2: single requester 2, full burst, bubble, regrant
      req_valid = 4'b0100;
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) push(2);
      tick();
      chk("t2_grant_id", 32'(grant_id), 32'd2);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_req_ready", 32'(req_ready), 32'b0100);
      tick(); tick(); tick();
      chk("t2_still_busy", 32'(busy), 32'd1);
      tick();
      chk("t2_bubble_busy", 32'(busy), 32'd0);
      chk("t2_bubble_valid", 32'(out_valid), 32'd0);
      chk("t2_bubble_gid_held", 32'(grant_id), 32'd2);
      tick();
      chk("t2_regrant_busy", 32'(busy), 32'd1);
      chk("t2_regrant_gid", 32'(grant_id), 32'd2);
      req_valid = '0;
      tick();
      chk("t2_release_busy", 32'(busy), 32'd0);
      chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

      // 3: full contention from fresh priority -> 0,1,2,3,0
      do_reset();
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++)
         for (int b = 0; b < 4; b++) push(g % 4);
      for (int g = 0; g < 5; g++) begin
         tick();
         chk("t3_grant_id", 32'(grant_id), 32'(g % 4));
         chk("t3_onehot_ready", 32'(req_ready), 32'(4'd1 << (g % 4)));
         tick(); tick(); tick();
         tick();
         chk("t3_bubble", 32'(busy), 32'd0);
      end
      req_valid = '0;
      tick();
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

      // 4: backpressure on requester 1 after two beats
      do_reset();
      req_valid = 4'b0010;
      for (int b = 0; b < 4; b++) push(1);
      tick();
      chk("t4_grant_id", 32'(grant_id), 32'd1);
      tick(); tick();
      out_ready = 1'b0;
      #1;
      chk("t4_bp_valid", 32'(out_valid), 32'd1);
      chk("t4_bp_ready", 32'(req_ready), 32'd0);
      chk("t4_q_two_left", 32'(exp_q.size()), 32'd2);
      tick(); tick(); tick();
      chk("t4_bp_busy", 32'(busy), 32'd1);
      chk("t4_bp_frozen", 32'(exp_q.size()), 32'd2);
      out_ready = 1'b1;
      tick(); tick();
      chk("t4_done_busy", 32'(busy), 32'd0);
      req_valid = '0;
      chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

      // 5: requester 3 releases after one beat; wrap to requester 0
      req_valid = 4'b1001;
      push(3);
      tick();
      chk("t5_grant_id", 32'(grant_id), 32'd3);
      chk("t5_req_ready", 32'(req_ready), 32'b1000);
      tick();
      req_valid = 4'b0001;
      tick();
      chk("t5_idle_busy", 32'(busy), 32'd0);
      tick();
      chk("t5_wrap_gid", 32'(grant_id), 32'd0);
      chk("t5_wrap_busy", 32'(busy), 32'd1);
      req_valid = '0;
      tick();
      chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

      // 6: reset during beat 2 of requester 2; priority restarts at 0
      req_valid = 4'b0100;
      push(2);
      tick();
      chk("t6_grant_id", 32'(grant_id), 32'd2);
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'd0);
      chk("t6_rst_gid", 32'(grant_id), 32'd0);
      req_valid = 4'b0110;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_new_gid", 32'(grant_id), 32'd1);
      chk("t6_new_busy", 32'(busy), 32'd1);
      req_valid = '0;
      tick();
      chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
Round-robin arbiter that shares one valid/ready slave port among NUM_REQ master-side requesters.
- Each requester presents valid/data.
- The arbiter grants one requester at a time and connects its valid/data to the slave side and the slave ready back to it.
- The grant is held for up to BURST_LEN handshakes before rotating.
- Sits between several master instances and a single slave instance in the bus-handshake designs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width; must equal ceil(log2(NUM_REQ))
DATA_W, 3, payload width per requester
BURST_LEN, 4, max handshakes per grant (1..255)

Ports:
sys_clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  valid per requester
req_data  in  NUM_REQ*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  ready back to each requester
out_valid  out  1  valid to slave
out_data  out  DATA_W  data to slave
out_ready  in  1  ready from slave
grant_id  out  ID_W  index of current/last granted requester
busy  out  1  1 while in GRANT

Behaviour:
Reset (rst_n=0, takes effect immediately, asynchronously):
- state=IDLE, grant_id=0, last_ptr=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0.
- Outputs: out_valid=0, out_data=0, req_ready=0, busy=0.

State IDLE:
- Outputs: out_valid=0, out_data=0, req_ready all 0, busy=0.
- If any req_valid=1, the winner is the first i with req_valid[i]=1, searching last_ptr+1, last_ptr+2, … with modulo-NUM_REQ wrap.
- Next edge: grant_id<=winner, last_ptr<=winner, beat_cnt<=0, state<=GRANT.
- Arbitration latency: 1 cycle from valid seen in IDLE to grant.
- If no req_valid, stay in IDLE.

State GRANT (g = grant_id):
- Combinational outputs: out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready, req_ready[j≠g]=0, busy=1.
- Handshake (hs) = out_valid & out_ready.
- On hs: beat_cnt increments.
- If hs and beat_cnt==BURST_LEN-1: state<=IDLE, beat_cnt<=0 (burst complete).
- Else if req_valid[g]=0: state<=IDLE (requester released early, zero-length tail). The grant is lost even if valid reasserts next cycle.
- Otherwise stay in GRANT.
- Backpressure (out_ready=0): no state change, beat_cnt held, out_data follows requester. The requester must hold its data.
- Non-granted requesters' valid/data are ignored and never acknowledged.

Boundaries and ordering:
- Each grant ends with one IDLE bubble cycle. Sustained throughput with out_ready=1 is BURST_LEN/(BURST_LEN+1).
- Single active requester: regranted after each bubble; rotation skips idle requesters.
- Simultaneous hs on the last beat and deassertion of that requester's valid: treated as burst complete, return to IDLE.
- Valid arriving in the same cycle as release is considered in the following IDLE cycle.
- beat_cnt width is 8 bits; it never exceeds BURST_LEN-1.
- grant_id retains its last value in IDLE.
- Reset mid-burst: the in-flight beat is dropped, nothing is acknowledged, and priority restarts at requester 0.
- No combinational path from out_ready to out_valid. The path out_ready→req_ready is purely combinational.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle → out_valid=0, req_ready=4'b0000, busy=0, grant_id=0 immediately, before any edge.
2. Single requester: req_valid=4'b0100, req_data[8:6]=3'b101, out_ready=1 →
   - grant_id=2, busy=1 one cycle later.
   - out_data=3'b101 for 4 hs cycles, then 1 IDLE cycle, then regrant to 2.
3. Full contention: req_valid=4'b1111, out_ready=1 → grant order 0,1,2,3,0. Each grant delivers exactly 4 beats; req_ready is one-hot on the granted index only.
4. Backpressure: requester 1 granted, out_ready=0 for 3 cycles after beat 2 → out_valid=1, req_ready[1]=0, beat count frozen. Burst then completes with exactly 4 total hs.
5. Early release: requester 3 granted; it drops valid after 1 hs while req_valid[0]=1 → IDLE next cycle, then grant_id=0 (wrap from last_ptr=3).
6. Reset mid-burst: assert rst_n=0 during beat 2 of requester 2, release with req_valid=4'b0110 → first new grant goes to requester 1, not 2.
